// File: rtl/fx_divider_param.sv
// fx_divider_param: sequential restoring fixed-point divider,
// unsigned or two's-complement, saturating on overflow.
module fx_divider_param #(
    parameter int WIDTH  = 10,
    parameter int FRAC   = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_out,
    output logic             dvz,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int L  = WIDTH + FRAC;
    localparam int CW = $clog2(L + 1);
    localparam logic [L:0] ONE   = {{L{1'b0}}, 1'b1};
    localparam logic [L:0] U_LIM = ONE << WIDTH;
    localparam logic [L:0] N_LIM = ONE << (WIDTH - 1);
    localparam logic [L:0] P_LIM = N_LIM - ONE;
    localparam logic [CW-1:0] N_STEPS = CW'(L);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nx;

    logic [CW-1:0]    cnt;
    logic [L-1:0]     dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             neg;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             take;
    logic [L-1:0]     raw;
    logic [L:0]       raw_x;
    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] q_val;
    logic [WIDTH-1:0] q_sat;
    logic [WIDTH-1:0] q_res;
    logic             res_ovf;
    logic             last;

    assign a_neg = (SIGNED != 0) && a_in[WIDTH-1];
    assign b_neg = (SIGNED != 0) && b_in[WIDTH-1];
    assign a_mag = a_neg ? WIDTH'(0) - a_in : a_in;
    assign b_mag = b_neg ? WIDTH'(0) - b_in : b_in;
    assign last  = (cnt == CW'(1));

    // One restoring step; the quotient bit shifts into the dividend register.
    always_comb begin
        rem_sh  = {rem, dvd[L-1]};
        take    = (rem_sh >= {1'b0, dvs});
        diff    = rem_sh[WIDTH-1:0] - dvs;
        raw     = {dvd[L-2:0], take};
        raw_x   = {1'b0, raw};
        mag     = raw[WIDTH-1:0];
        q_val   = neg ? WIDTH'(0) - mag : mag;
        res_ovf = 1'b0;
        q_sat   = '1;
        if (SIGNED == 0) begin
            res_ovf = (raw_x >= U_LIM);
            q_sat   = '1;
        end else if (neg) begin
            res_ovf = (raw_x > N_LIM);
            q_sat   = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            res_ovf = (raw_x > P_LIM);
            q_sat   = {1'b0, {(WIDTH-1){1'b1}}};
        end
        q_res = res_ovf ? q_sat : q_val;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (b_in == '0) ? DONE : CALC;
            CALC: if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (sclr) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dvd   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            q_out <= '0;
            dvz   <= 1'b0;
            ovf   <= 1'b0;
        end else if (sclr) begin
            cnt   <= '0;
            dvd   <= '0;
            rem   <= '0;
            dvs   <= '0;
            neg   <= 1'b0;
            q_out <= '0;
            dvz   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dvs <= b_mag;
                        dvd <= L'(a_mag) << FRAC;
                        rem <= '0;
                        neg <= a_neg ^ b_neg;
                        cnt <= N_STEPS;
                        if (b_in == '0) begin
                            q_out <= '0;
                            dvz   <= 1'b1;
                            ovf   <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= take ? diff : rem_sh[WIDTH-1:0];
                    dvd <= raw;
                    cnt <= cnt - CW'(1);
                    if (last) begin
                        q_out <= q_res;
                        ovf   <= res_ovf;
                        dvz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == CALC);
    assign valid = (state == DONE);

endmodule

// File: tb/tb_fx_divider_param.sv
// Scoreboard bench for fx_divider_param: unsigned, signed and
// 16-bit Q8.8 instances driven with directed vectors.
module tb_fx_divider_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclr = 1'b0;
    logic [2:0]  st = '0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic [9:0]  q0, q1;
    logic [15:0] q2;
    logic [2:0]  dvz, ovf, busy, vld;

    typedef struct packed {
        logic [15:0] q;
        logic        dvz;
        logic        ovf;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fx_divider_param #(.WIDTH(10), .FRAC(4), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(st[0]),
        .a_in(a[9:0]), .b_in(b[9:0]), .q_out(q0), .dvz(dvz[0]),
        .ovf(ovf[0]), .busy(busy[0]), .valid(vld[0])
    );

    fx_divider_param #(.WIDTH(10), .FRAC(4), .SIGNED(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(st[1]),
        .a_in(a[9:0]), .b_in(b[9:0]), .q_out(q1), .dvz(dvz[1]),
        .ovf(ovf[1]), .busy(busy[1]), .valid(vld[1])
    );

    fx_divider_param #(.WIDTH(16), .FRAC(8), .SIGNED(0)) u2 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(st[2]),
        .a_in(a), .b_in(b), .q_out(q2), .dvz(dvz[2]),
        .ovf(ovf[2]), .busy(busy[2]), .valid(vld[2])
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int sbsize(input int d);
        case (d)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic score(input int d, input logic [15:0] qv,
                         input logic dv, input logic ov);
        exp_t e;
        if (sbsize(d) == 0) begin
            check($sformatf("d%0d_unexpected_valid", d), 32'(1), 32'(0));
        end else begin
            case (d)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            check($sformatf("d%0d_q", d), 32'(qv), 32'(e.q));
            check($sformatf("d%0d_dvz", d), 32'(dv), 32'(e.dvz));
            check($sformatf("d%0d_ovf", d), 32'(ov), 32'(e.ovf));
        end
    endtask

    always @(negedge clk) if (vld[0]) score(0, {6'b0, q0}, dvz[0], ovf[0]);
    always @(negedge clk) if (vld[1]) score(1, {6'b0, q1}, dvz[1], ovf[1]);
    always @(negedge clk) if (vld[2]) score(2, q2, dvz[2], ovf[2]);

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input int d, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] eq,
                         input logic ed, input logic eo, input bit push);
        exp_t e;
        e.q = eq;
        e.dvz = ed;
        e.ovf = eo;
        if (push) begin
            case (d)
                0:       sb0.push_back(e);
                1:       sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
        end
        a = av;
        b = bv;
        st[d] = 1'b1;
        @(negedge clk);
        st[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int c = 0;
        while (sbsize(d) != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (sbsize(d) != 0) begin
            check($sformatf("d%0d_timeout", d), 32'(sbsize(d)), 32'(0));
            case (d)
                0:       sb0.delete();
                1:       sb1.delete();
                default: sb2.delete();
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        int c;
        int bc;

        #12;
        check("rst_q", 32'(q0), 32'(0));
        check("rst_dvz", 32'(dvz[0]), 32'(0));
        check("rst_ovf", 32'(ovf[0]), 32'(0));
        check("rst_busy", 32'(busy[0]), 32'(0));
        check("rst_valid", 32'(vld[0]), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 21.0 / 0.25 overflows; check latency and busy window
        issue(0, 16'h150, 16'h004, 16'h3FF, 1'b0, 1'b1, 1'b1);
        c = 0;
        bc = 0;
        while (!vld[0] && c < 40) begin
            if (busy[0]) bc++;
            @(negedge clk);
            c++;
        end
        check("ovf_latency", 32'(c), 32'(14));
        check("ovf_busy_cycles", 32'(bc), 32'(14));
        check("ovf_busy_at_valid", 32'(busy[0]), 32'(0));
        @(negedge clk);
        check("valid_one_cycle", 32'(vld[0]), 32'(0));
        wait_done(0);

        // divide by zero
        issue(0, 16'h150, 16'h000, 16'h000, 1'b1, 1'b0, 1'b1);
        check("dvz_valid_next", 32'(vld[0]), 32'(1));
        check("dvz_busy", 32'(busy[0]), 32'(0));
        @(negedge clk);
        check("dvz_valid_drop", 32'(vld[0]), 32'(0));
        wait_done(0);

        issue(0, 16'h030, 16'h018, 16'h020, 1'b0, 1'b0, 1'b1);
        wait_done(0);
        issue(0, 16'h010, 16'h030, 16'h005, 1'b0, 1'b0, 1'b1);
        wait_done(0);

        issue(1, 16'h3D0, 16'h018, 16'h3E0, 1'b0, 1'b0, 1'b1);
        wait_done(1);
        issue(1, 16'h200, 16'h3FF, 16'h1FF, 1'b0, 1'b1, 1'b1);
        wait_done(1);
        issue(1, 16'h200, 16'h010, 16'h200, 1'b0, 1'b0, 1'b1);
        wait_done(1);

        // asynchronous reset mid-operation
        issue(0, 16'h150, 16'h004, 16'h3FF, 1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        st[0] = 1'b1;
        #1;
        check("arst_q", 32'(q0), 32'(0));
        check("arst_busy", 32'(busy[0]), 32'(0));
        check("arst_valid", 32'(vld[0]), 32'(0));
        repeat (2) @(negedge clk);
        check("arst_hold_busy", 32'(busy[0]), 32'(0));
        st[0] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 16'h030, 16'h018, 16'h020, 1'b0, 1'b0, 1'b1);
        wait_done(0);

        // operands captured at acceptance; later inputs ignored
        issue(0, 16'h030, 16'h018, 16'h020, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            st[0] = ~st[0];
            a = 16'h155 + 16'(i);
            b = 16'h001;
            @(negedge clk);
        end
        st[0] = 1'b0;
        wait_done(0);

        // synchronous clear aborts without a valid pulse
        issue(0, 16'h150, 16'h004, 16'h3FF, 1'b0, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        sclr = 1'b1;
        @(negedge clk);
        check("sclr_busy", 32'(busy[0]), 32'(0));
        check("sclr_valid", 32'(vld[0]), 32'(0));
        check("sclr_q", 32'(q0), 32'(0));
        sclr = 1'b0;
        repeat (20) @(negedge clk);
        check("sclr_idle_busy", 32'(busy[0]), 32'(0));

        // Q8.8: 100.0 / 3.0
        issue(2, 16'h6400, 16'h0300, 16'h2155, 1'b0, 1'b0, 1'b1);
        c = 0;
        while (!vld[2] && c < 60) begin
            @(negedge clk);
            c++;
        end
        check("w16_latency", 32'(c), 32'(24));
        wait_done(2);

        check("sb_left", 32'(sbsize(0) + sbsize(1) + sbsize(2)), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fx_divider_param.md
# fx_divider_param

Parametrised sequential fixed-point divider. It computes q = a / b on WIDTH-bit operands with FRAC fractional bits, in unsigned or two's-complement signed mode, using one restoring-division step per clock. It replaces the fixed 10-bit Q6.4 unsigned divider and keeps its start/busy/valid handshake and its dvz/ovf flags. It adds width, fraction and signedness generics, saturation on overflow, and an asynchronous reset.

## Interface
- WIDTH, 10, operand and quotient width in bits; legal range 4..32.
- FRAC, 4, fractional bits of a, b and q; legal range 0..WIDTH-1.
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands and quotient.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; asynchronous and active-low.
- sclr  input  1  synchronous clear, active-high; priority over start.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  dividend; captured on the accepting edge.
- b_in  input  WIDTH  divisor; captured on the accepting edge.
- q_out  output  WIDTH  quotient; registered; holds until the next result.
- dvz  output  1  divide-by-zero flag for the last result.
- ovf  output  1  overflow flag for the last result.
- busy  output  1  high while an operation is in progress.
- valid  output  1  one-cycle pulse: q_out, dvz and ovf are new.

## Operation
- States: IDLE, CALC, DONE.
- IDLE: start=1 at a rising edge does the following:
  - Captures a_in and b_in.
  - Loads N = WIDTH+FRAC into the step counter.
  - Goes to CALC and sets busy=1.
  - If b_in==0, goes to DONE instead, with dvz=1, ovf=0, q_out=0.
- Signed mode: operand magnitudes are taken at capture and the result sign is sign(a) XOR sign(b). Magnitude of the most negative value = 2^(WIDTH-1), held in a WIDTH-bit unsigned register.
- CALC: dividend = |a| << FRAC, which is WIDTH+FRAC bits. Each cycle performs one restoring step, MSB first, with a (WIDTH+1)-bit partial remainder. The counter decrements; when it reaches 0 the state goes to DONE.
- Result rules at the CALC->DONE edge:
  - The raw quotient is WIDTH+FRAC bits, truncated toward zero.
  - Unsigned: ovf=1 if raw >= 2^WIDTH; q_out then saturates to all ones.
  - Signed positive result: ovf=1 if raw > 2^(WIDTH-1)-1; q_out saturates to 0111..1.
  - Signed negative result: ovf=1 if raw > 2^(WIDTH-1); q_out saturates to 1000..0.
  - Otherwise q_out = raw, negated if the result sign is negative.
  - dvz=0.
- DONE: valid=1 and busy=0 for exactly one cycle, then IDLE unconditionally. start is not sampled in DONE.
- start during CALC or DONE is ignored; captured operands are unaffected by later changes on a_in and b_in.
- sclr=1 at an edge, in any state: go to IDLE and clear all outputs and internal registers to their reset values. An aborted operation produces no valid pulse.
- rst_n low: immediately state=IDLE, q_out=0, dvz=0, ovf=0, busy=0, valid=0, counter=0.

## Timing
- Edge E0 samples start in IDLE. busy is high after E0.
- Normal case: CALC runs on edges E1..EN. At EN the state becomes DONE, q_out, ovf and dvz update, valid=1 and busy=0. With defaults, N=14.
- Divide-by-zero case: at E0 the state becomes DONE, so valid appears one cycle after acceptance. busy stays 0 throughout.
- Throughput: one accepted operation every N+2 cycles when start is held high; 2 cycles for dvz.
- dvz and ovf are never both 1. Both flags and q_out hold until the next DONE, sclr, or reset.
- rst_n assertion mid-CALC clears outputs without waiting for a clock edge. Release is synchronised by the integrator.

## Test plan
- Defaults, a=10'b0101010000 (21.0), b=10'b0000000100 (0.25) -> valid at E14, ovf=1, dvz=0, q_out=10'h3FF; busy high E0..E14.
- Defaults, a=10'h030 (3.0), b=10'h018 (1.5) -> q_out=10'h020 (2.0), ovf=0. a=10'h010, b=10'h030 (1/3) -> q_out=10'h005, truncated.
- Defaults, b=0, a=10'h150 -> dvz=1, ovf=0, q_out=0, valid one cycle after E0, busy never high.
- SIGNED=1 cases:
  - a=10'h3D0 (-3.0), b=10'h018 -> q_out=10'h3E0 (-2.0).
  - a=10'h200, b=10'h3FF -> ovf=1, q_out=10'h1FF.
  - a=10'h200, b=10'h010 -> q_out=10'h200, ovf=0.
- Start 21/0.25, then drive rst_n=0 at E5 and hold start=1 across the next E0 -> outputs 0 immediately, no valid pulse. After rst_n=1, a new op with a=10'h030, b=10'h018 completes normally with q_out=10'h020.
- Toggle start and change a_in/b_in during CALC -> result uses the originally captured operands. sclr=1 at E7 -> busy=0 at E7, no valid pulse. WIDTH=16, FRAC=8: 100.0/3.0 -> q_out=16'h2155 at E24.
